basereg: RTL and testbench

BASEREG -- requirements
Module: basereg

---
 rtl/basereg_pkg.sv | 27 ++
 rtl/basereg_scoreboard.sv | 57 +++++
 rtl/basereg.sv | 92 +++++++++
 tb/tb_basereg.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/basereg_pkg.sv
// Shared widths, types and helpers for the base register file and its pending-write scoreboard.
// Optional feature macro: BASEREG_BYPASS_EN (writeback-to-read forwarding).
package basereg_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned ADDR_W    = $clog2(REG_COUNT);
  localparam int unsigned PEND_W    = 2;

  typedef logic [XLEN-1:0]   xword_t;
  typedef logic [ADDR_W-1:0] raddr_t;
  typedef logic [PEND_W-1:0] pend_t;

  localparam pend_t PEND_MAX = '1;

  // Qualified writeback request: en is only set for a real (nonzero) destination.
  typedef struct packed {
    logic   en;
    raddr_t addr;
    xword_t data;
  } wb_req_t;

  function automatic logic is_nonzero(input raddr_t addr);
    return addr != '0;
  endfunction

endpackage

// File: rtl/basereg_scoreboard.sv
// Per-register pending-write counters: issue increments, writeback decrements, full detection.
// Counts saturate at zero on decrement; increments are blocked at PEND_MAX via full_c.
module basereg_scoreboard
  import basereg_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   issue,
  input  raddr_t issue_addr,
  input  logic   issue_go,
  input  logic   dec_en,
  input  raddr_t dec_addr,
  input  raddr_t rs1_addr,
  input  raddr_t rs2_addr,
  output pend_t  rs1_cnt_c,
  output pend_t  rs2_cnt_c,
  output logic   full_c
);

  pend_t                cnt_q [REG_COUNT];
  logic [REG_COUNT-1:0] inc_c;
  logic [REG_COUNT-1:0] dec_c;

  // One-hot increment/decrement requests; index 0 is never selected so x0 never goes pending.
  always_comb begin
    inc_c  = '0;
    dec_c  = '0;
    full_c = issue && (cnt_q[issue_addr] == PEND_MAX);
    if (issue && issue_go && !full_c && is_nonzero(issue_addr)) begin
      inc_c[issue_addr] = 1'b1;
    end
    if (dec_en && is_nonzero(dec_addr)) begin
      dec_c[dec_addr] = 1'b1;
    end
  end

  // Simultaneous increment and decrement on one register cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (inc_c[i] && !dec_c[i]) begin
          cnt_q[i] <= cnt_q[i] + PEND_W'(1);
        end else if (dec_c[i] && !inc_c[i] && (cnt_q[i] != '0)) begin
          cnt_q[i] <= cnt_q[i] - PEND_W'(1);
        end
      end
    end
  end

  assign rs1_cnt_c = cnt_q[rs1_addr];
  assign rs2_cnt_c = cnt_q[rs2_addr];

endmodule

// File: rtl/basereg.sv
// RV32I base register file with registered read ports and RAW/scoreboard-full stall generation.
// Define BASEREG_BYPASS_EN to forward a same-cycle final writeback into the read registers.
module basereg
  import basereg_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_ce,
  input  logic [ADDR_W-1:0]  i_rs1_addr,
  input  logic [ADDR_W-1:0]  i_rs2_addr,
  output logic [XLEN-1:0]    o_rs1,
  output logic [XLEN-1:0]    o_rs2,
  input  logic               i_wr,
  input  logic [ADDR_W-1:0]  i_rd_addr,
  input  logic [XLEN-1:0]    i_rd,
  input  logic               i_issue,
  input  logic [ADDR_W-1:0]  i_issue_rd_addr,
  output logic               o_hazard
);

  xword_t  regs_q [REG_COUNT];
  wb_req_t wb_c;
  pend_t   rs1_cnt_c;
  pend_t   rs2_cnt_c;
  logic    full_c;
  logic    rs1_byp_c;
  logic    rs2_byp_c;
  logic    rs1_haz_c;
  logic    rs2_haz_c;
  logic    hazard_c;
  logic    read_go_c;
  xword_t  rs1_val_c;
  xword_t  rs2_val_c;

  assign wb_c = '{en: i_wr && is_nonzero(i_rd_addr), addr: i_rd_addr, data: i_rd};

  basereg_scoreboard u_scoreboard (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .issue      (i_issue),
    .issue_addr (i_issue_rd_addr),
    .issue_go   (read_go_c),
    .dec_en     (wb_c.en),
    .dec_addr   (wb_c.addr),
    .rs1_addr   (i_rs1_addr),
    .rs2_addr   (i_rs2_addr),
    .rs1_cnt_c  (rs1_cnt_c),
    .rs2_cnt_c  (rs2_cnt_c),
    .full_c     (full_c)
  );

  // Source hazards; a source is released by forwarding only when this write retires its last pending issue.
  always_comb begin
    rs1_byp_c = 1'b0;
    rs2_byp_c = 1'b0;
`ifdef BASEREG_BYPASS_EN
    rs1_byp_c = wb_c.en && (wb_c.addr == i_rs1_addr) && (rs1_cnt_c == PEND_W'(1));
    rs2_byp_c = wb_c.en && (wb_c.addr == i_rs2_addr) && (rs2_cnt_c == PEND_W'(1));
`endif
    rs1_haz_c = is_nonzero(i_rs1_addr) && (rs1_cnt_c != '0) && !rs1_byp_c;
    rs2_haz_c = is_nonzero(i_rs2_addr) && (rs2_cnt_c != '0) && !rs2_byp_c;
    hazard_c  = rs1_haz_c || rs2_haz_c || full_c;
    read_go_c = i_ce && !hazard_c;
    rs1_val_c = rs1_byp_c ? wb_c.data : regs_q[i_rs1_addr];
    rs2_val_c = rs2_byp_c ? wb_c.data : regs_q[i_rs2_addr];
  end

  assign o_hazard = hazard_c;

  // Storage; entry 0 is cleared on reset and never written, so x0 always reads zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_c.en) begin
      regs_q[wb_c.addr] <= wb_c.data;
    end
  end

  // Operand read registers; stall or disabled stage holds the previous operands.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rs1 <= '0;
      o_rs2 <= '0;
    end else if (read_go_c) begin
      o_rs1 <= rs1_val_c;
      o_rs2 <= rs2_val_c;
    end
  end

endmodule

// File: tb/tb_basereg.sv
// Scoreboard bench for basereg: a behavioural model predicts hazards and queued operand reads.
// Follows the BASEREG_BYPASS_EN build setting of the design.
module tb_basereg;

`ifdef BASEREG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_ce;
  logic [4:0]  i_rs1_addr;
  logic [4:0]  i_rs2_addr;
  logic [31:0] o_rs1;
  logic [31:0] o_rs2;
  logic        i_wr;
  logic [4:0]  i_rd_addr;
  logic [31:0] i_rd;
  logic        i_issue;
  logic [4:0]  i_issue_rd_addr;
  logic        o_hazard;

  basereg dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_ce            (i_ce),
    .i_rs1_addr      (i_rs1_addr),
    .i_rs2_addr      (i_rs2_addr),
    .o_rs1           (o_rs1),
    .o_rs2           (o_rs2),
    .i_wr            (i_wr),
    .i_rd_addr       (i_rd_addr),
    .i_rd            (i_rd),
    .i_issue         (i_issue),
    .i_issue_rd_addr (i_issue_rd_addr),
    .o_hazard        (o_hazard)
  );

  always #5 i_clk = ~i_clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_reg [32];
  int          m_cnt [32];
  logic [31:0] exp_q [$];
  logic [31:0] last_rs1;
  logic [31:0] last_rs2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit src_byp(input logic [4:0] a);
    return BYP && i_wr && (i_rd_addr == a) && (a != 5'd0) && (m_cnt[a] == 1);
  endfunction

  function automatic bit src_haz(input logic [4:0] a);
    return (a != 5'd0) && (m_cnt[a] != 0) && !src_byp(a);
  endfunction

  function automatic logic [31:0] src_val(input logic [4:0] a);
    return src_byp(a) ? i_rd : m_reg[a];
  endfunction

  function automatic bit m_hazard();
    return src_haz(i_rs1_addr) || src_haz(i_rs2_addr) ||
           (i_issue && (m_cnt[i_issue_rd_addr] == 3));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = '0;
      m_cnt[i] = 0;
    end
    exp_q.delete();
    last_rs1 = '0;
    last_rs2 = '0;
  endtask

  task automatic drive(input bit ce, input logic [4:0] rs1, input logic [4:0] rs2,
                       input bit wr, input logic [4:0] ra, input logic [31:0] rd,
                       input bit iss, input logic [4:0] ia);
    i_ce = ce; i_rs1_addr = rs1; i_rs2_addr = rs2;
    i_wr = wr; i_rd_addr = ra; i_rd = rd;
    i_issue = iss; i_issue_rd_addr = ia;
  endtask

  // One clock: check hazard mid-cycle, queue expected operands, advance model, compare after the edge.
  task automatic cycle();
    bit haz, go, inc, dec;
    @(negedge i_clk);
    haz = m_hazard();
    check("hazard", 32'(o_hazard), 32'(haz));
    go = i_ce && !haz;
    if (go) begin
      exp_q.push_back(src_val(i_rs1_addr));
      exp_q.push_back(src_val(i_rs2_addr));
    end
    inc = go && i_issue && (i_issue_rd_addr != 5'd0);
    dec = i_wr && (i_rd_addr != 5'd0);
    if (!(inc && dec && (i_issue_rd_addr == i_rd_addr))) begin
      if (inc) m_cnt[i_issue_rd_addr]++;
      if (dec && (m_cnt[i_rd_addr] > 0)) m_cnt[i_rd_addr]--;
    end
    if (dec) m_reg[i_rd_addr] = i_rd;
    @(posedge i_clk);
    #1;
    if (go && (exp_q.size() >= 2)) begin
      last_rs1 = exp_q.pop_front();
      last_rs2 = exp_q.pop_front();
    end
    check("rs1", o_rs1, last_rs1);
    check("rs2", o_rs2, last_rs2);
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    i_rst_n = 1'b0;
    idle();
    #3;
    check("reset_rs1", o_rs1, 32'd0);
    check("reset_rs2", o_rs2, 32'd0);
    check("reset_hazard", 32'(o_hazard), 32'd0);
    #9;
    i_rst_n = 1'b1;

    // Write x5, then read it back.
    drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0); cycle();
    drive(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);        cycle();
    check("x5_readback", o_rs1, 32'hDEADBEEF);

    // x0 ignores writes and issues.
    drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0);     cycle();
    drive(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);        cycle();
    check("x0_read", o_rs2, 32'd0);
    drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
    #1 check("x0_issue_nohaz", 32'(o_hazard), 32'd0);
    cycle();

    // RAW on x3, resolved by writeback of 0x55.
    drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);        cycle();
    drive(1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    #1 check("raw_x3", 32'(o_hazard), 32'd1);
    cycle();
    drive(1'b1, 5'd3, 5'd0, 1'b1, 5'd3, 32'h55, 1'b0, 5'd0);
    #1 check("raw_x3_wb", 32'(o_hazard), BYP ? 32'd0 : 32'd1);
    cycle();
    drive(1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    #1 check("raw_x3_release", 32'(o_hazard), 32'd0);
    cycle();
    check("x3_value", o_rs1, 32'h55);

    // Scoreboard full on x7.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7); cycle();
    end
    drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    #1 check("x7_full", 32'(o_hazard), 32'd1);
    cycle();
    drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0);       cycle();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    #1 check("x7_not_full", 32'(o_hazard), 32'd0);
    cycle();

    // Same-cycle issue and writeback on x9 leave the count at 1.
    drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);        cycle();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9);       cycle();
    drive(1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    #1 check("x9_still_pending", 32'(o_hazard), 32'd1);
    cycle();
    drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd9, 32'h999, 1'b0, 5'd0);      cycle();
    drive(1'b1, 5'd9, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);        cycle();

    // Random traffic over a few registers.
    for (int n = 0; n < 200; n++) begin
      drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)));
      cycle();
    end

    // Mid-operation reset with x4 written and counts pending.
    drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd4, 32'hA5, 1'b0, 5'd0);       cycle();
    drive(1'b1, 5'd4, 5'd4, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4);        cycle();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6);        cycle();
    drive(1'b1, 5'd6, 5'd4, 1'b1, 5'd4, 32'hFF, 1'b1, 5'd6);
    i_rst_n = 1'b0;
    #2;
    check("rst_rs1", o_rs1, 32'd0);
    check("rst_rs2", o_rs2, 32'd0);
    check("rst_hazard", 32'(o_hazard), 32'd0);
    @(negedge i_clk);
    check("rst_hold_hazard", 32'(o_hazard), 32'd0);
    idle();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    model_reset();
    drive(1'b1, 5'd4, 5'd6, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    #1 check("post_rst_nohaz", 32'(o_hazard), 32'd0);
    cycle();
    check("post_rst_x4", o_rs1, 32'd0);
    drive(1'b1, 5'd7, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);        cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
